// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   PC_W_DEF / INSTR_W_DEF : default program-counter and instruction widths
//   NOP                    : instruction presented when no entry is valid
//   fetch_entry_t          : one buffered fetch result {pc, instr}
package cpu_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_queue_fifo_ptr.sv
// fifo_ptr: pointer and occupancy bookkeeping for a power-of-two circular buffer.
// Ports:
//   clock, rst          rising-edge clock, asynchronous active-low reset
//   push, pop           qualified push/pop events (already handshaken)
//   flush               empties the buffer; wins over push and pop
//   wr_ptr, rd_ptr      write/read slot indices, wrap modulo DEPTH
//   count               current occupancy (0..DEPTH)
//   full, empty         decoded from count
module fifo_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Dropping everything only needs the read side to catch up with the
      // write side; storage contents are left as they are.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_queue.sv
// if_queue: DEPTH-entry instruction queue between fetch and decode.
// Optional feature macro: IF_QUEUE_BYPASS_EN (empty-queue fall-through,
// zero-cycle push-to-pop latency). Default build has 1-cycle latency.
// Ports:
//   clock, rst                        rising-edge clock, async active-low reset
//   push_valid/push_ready             fetch-side handshake
//   push_pc, push_instr               fetched entry
//   pop_valid/pop_ready               decode-side handshake
//   pop_pc, pop_instr                 head entry (0 / NOP when pop_valid=0)
//   flush                             discard all entries (taken branch)
//   count                             current occupancy
module if_queue
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [PC_W-1:0]            push_pc,
  input  logic [INSTR_W-1:0]         push_instr,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [PC_W-1:0]            pop_pc,
  output logic [INSTR_W-1:0]         pop_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push_fire;
  logic             pop_fire;

  fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clock  (clock),
    .rst    (rst),
    .push   (push_fire),
    .pop    (pop_fire),
    .flush  (flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    bypass = 1'b0;
`ifdef IF_QUEUE_BYPASS_EN
    bypass = empty && push_valid && !flush;
`endif
    // push_ready is a function of registered occupancy only.
    push_ready = !full;
    pop_valid  = !empty || bypass;
    // A bypassed entry that decode takes immediately never touches storage.
    push_fire  = push_valid && !full && !flush && !(bypass && pop_ready);
    pop_fire   = !empty && pop_ready && !flush;

    if (bypass) begin
      pop_pc    = push_pc;
      pop_instr = push_instr;
    end else if (!empty) begin
      pop_pc    = PC_W'(mem[rd_ptr].pc);
      pop_instr = INSTR_W'(mem[rd_ptr].instr);
    end else begin
      pop_pc    = '0;
      pop_instr = INSTR_W'(NOP);
    end
  end

  always_ff @(posedge clock) begin
    if (push_fire) begin
      mem[wr_ptr].pc    <= PC_W_DEF'(push_pc);
      mem[wr_ptr].instr <= INSTR_W_DEF'(push_instr);
    end
  end

endmodule

// File: tb/tb_if_queue.sv
// Self-checking bench for if_queue (DEPTH=4) against a queue-based model.
// Define IF_QUEUE_BYPASS_EN for both RTL and bench to exercise fall-through.
module tb_if_queue;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        rst;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];

  if_queue #(.PC_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_pc    (push_pc),
    .push_instr (push_instr),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_pc     (pop_pc),
    .pop_instr  (pop_instr),
    .flush      (flush),
    .count      (count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: does the current input set fall through an empty queue?
  function automatic bit byp_now();
`ifdef IF_QUEUE_BYPASS_EN
    return (q.size() == 0) && push_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_pop_valid();
    return (q.size() != 0) || byp_now();
  endfunction

  function automatic logic [31:0] exp_pc();
    if (byp_now()) return push_pc;
    if (q.size() != 0) return q[0].pc;
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_instr();
    if (byp_now()) return push_instr;
    if (q.size() != 0) return q[0].instr;
    return 32'h0;
  endfunction

  // Advance one clock edge and apply the queue semantics to the model.
  task automatic tick();
    bit pv, do_pop, do_push, byp;
    ent_t e;
    @(posedge clock);
    pv = exp_pop_valid();
    byp = byp_now();
    if (!rst || flush) begin
      q.delete();
    end else begin
      do_pop  = pv && pop_ready;
      do_push = push_valid && (q.size() != DEPTH);
      if (!(byp && pop_ready)) begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          e.pc = push_pc;
          e.instr = push_instr;
          q.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0;
    push_pc    = '0;
    push_instr = '0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_pc    = base + 32'(4 * i);
      push_instr = $urandom;
      pop_ready  = 1'b0;
      tick();
    end
    push_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    q.delete();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (pop_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: pop_valid=%b count=%0d, want 0/0", pop_valid, count);
    end
    rst = 1'b1;
    #3;
    checks++;
    if (push_ready !== 1'b1 || pop_valid !== 1'b0 || pop_instr !== 32'h0 ||
        pop_pc !== 32'h0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: push_ready=%b pop_valid=%b pop_pc=%h pop_instr=%h count=%0d, want 1/0/0/0/0",
               push_ready, pop_valid, pop_pc, pop_instr, count);
    end
    tick();
  endtask

  task automatic test_fill_full();
    logic [31:0] ins [4];
    pop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_pc    = 32'(4 * i);
      push_instr = $urandom;
      ins[i]     = push_instr;
      #3;
      checks++;
      if (push_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready[%0d]: push_ready=%b, want 1", i, push_ready);
      end
      tick();
      checks++;
      if (count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_count[%0d]: count=%0d, want %0d", i, count, i + 1);
      end
    end
    push_pc = 32'h10;
    push_instr = $urandom;
    #3;
    checks++;
    if (push_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: push_ready=%b, want 0", push_ready);
    end
    tick();
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_ignore: count=%0d, want 4", count);
    end
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++;
      if (pop_valid !== 1'b1 || pop_pc !== 32'(4 * i) || pop_instr !== ins[i]) begin
        errors++;
        $display("FAIL drain[%0d]: pop_valid=%b pop_pc=%h pop_instr=%h, want 1/%h/%h",
                 i, pop_valid, pop_pc, pop_instr, 32'(4 * i), ins[i]);
      end
      tick();
    end
    pop_ready = 1'b0;
    #3;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || pop_instr !== 32'h0) begin
      errors++;
      $display("FAIL drain_empty: count=%0d pop_valid=%b pop_instr=%h, want 0/0/0",
               count, pop_valid, pop_instr);
    end
    tick();
  endtask

  task automatic test_streaming();
    push_n(2, 32'h100);
    for (int k = 0; k < 10; k++) begin
      push_valid = 1'b1;
      push_pc    = 32'h108 + 32'(4 * k);
      push_instr = $urandom;
      pop_ready  = 1'b1;
      #3;
      checks++;
      if (pop_pc !== 32'h100 + 32'(4 * k) || pop_pc !== exp_pc() || pop_instr !== exp_instr()) begin
        errors++;
        $display("FAIL stream_pc[%0d]: pop_pc=%h pop_instr=%h, want %h/%h",
                 k, pop_pc, pop_instr, 32'h100 + 32'(4 * k), exp_instr());
      end
      tick();
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL stream_count[%0d]: count=%0d, want 2", k, count);
      end
    end
    push_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #3;
      checks++;
      if (pop_pc !== 32'h128 + 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_tail[%0d]: pop_pc=%h, want %h", k, pop_pc, 32'h128 + 32'(4 * k));
      end
      tick();
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_flush();
    push_n(3, 32'h200);
    flush      = 1'b1;
    push_valid = 1'b1;
    push_pc    = 32'h300;
    push_instr = $urandom;
    pop_ready  = 1'b1;
    tick();
    idle_inputs();
    #3;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || pop_instr !== 32'h0 || pop_pc !== 32'h0) begin
      errors++;
      $display("FAIL flush_empty: count=%0d pop_valid=%b pop_pc=%h pop_instr=%h, want 0/0/0/0",
               count, pop_valid, pop_pc, pop_instr);
    end
    tick();
    push_n(1, 32'h40);
    pop_ready = 1'b1;
    #3;
    checks++;
    if (pop_valid !== 1'b1 || pop_pc !== 32'h40) begin
      errors++;
      $display("FAIL flush_after: pop_valid=%b pop_pc=%h, want 1/00000040", pop_valid, pop_pc);
    end
    tick();
    pop_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL flush_after_count: count=%0d, want 0", count);
    end
  endtask

  task automatic test_async_reset();
    push_n(3, 32'h500);
    #3;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL areset_pre: count=%0d, want 3", count);
    end
    rst = 1'b0;
    #1;
    q.delete();
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || pop_instr !== 32'h0 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: count=%0d pop_valid=%b pop_instr=%h push_ready=%b, want 0/0/0/1",
               count, pop_valid, pop_instr, push_ready);
    end
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] ins;
    idle_inputs();
    ins        = $urandom;
    push_valid = 1'b1;
    push_pc    = 32'h20;
    push_instr = ins;
    pop_ready  = 1'b1;
    #3;
`ifdef IF_QUEUE_BYPASS_EN
    checks++;
    if (pop_valid !== 1'b1 || pop_pc !== 32'h20 || pop_instr !== ins) begin
      errors++;
      $display("FAIL bypass_same: pop_valid=%b pop_pc=%h pop_instr=%h, want 1/00000020/%h",
               pop_valid, pop_pc, pop_instr, ins);
    end
    tick();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL bypass_count: count=%0d, want 0", count);
    end
`else
    checks++;
    if (pop_valid !== 1'b0 || pop_pc !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same: pop_valid=%b pop_pc=%h, want 0/0", pop_valid, pop_pc);
    end
    tick();
    push_valid = 1'b0;
    #3;
    checks++;
    if (pop_valid !== 1'b1 || pop_pc !== 32'h20 || pop_instr !== ins || count !== 3'd1) begin
      errors++;
      $display("FAIL nobypass_next: pop_valid=%b pop_pc=%h pop_instr=%h count=%0d, want 1/00000020/%h/1",
               pop_valid, pop_pc, pop_instr, count, ins);
    end
    tick();
    pop_ready = 1'b0;
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      push_instr = $urandom;
      pop_ready  = $urandom_range(0, 1) != 0;
      flush      = ($urandom_range(0, 15) == 0);
      #3;
      checks++;
      if (push_ready !== (q.size() != DEPTH) || pop_valid !== exp_pop_valid() ||
          pop_pc !== exp_pc() || pop_instr !== exp_instr() || count !== 3'(q.size())) begin
        errors++;
        $display("FAIL random[%0d]: ready=%b valid=%b pc=%h instr=%h count=%0d, want %b/%b/%h/%h/%0d",
                 c, push_ready, pop_valid, pop_pc, pop_instr, count,
                 q.size() != DEPTH, exp_pop_valid(), exp_pc(), exp_instr(), q.size());
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_streaming();
    test_flush();
    test_async_reset();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
